// File: rtl/lab_access_pkg.sv
// Shared encodings and types for the lab access requester and its request FIFO.
package lab_access_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned REQ_W  = CODE_W + 2;

  localparam logic [1:0] MODE_EXIT  = 2'b00;
  localparam logic [1:0] MODE_ENTER = 2'b01;
  localparam logic [1:0] MODE_IDLE  = 2'b10;

  localparam logic LAB_DIGITAL = 1'b0;
  localparam logic LAB_MERA    = 1'b1;

  typedef enum logic [2:0] {
    RES_GRANT         = 3'd0,
    RES_DENY_RESTRICT = 3'd1,
    RES_DENY_FULL     = 3'd2,
    RES_DENY_EMPTY    = 3'd3,
    RES_TIMEOUT       = 3'd4
  } lab_result_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } lab_state_t;

  // One queued door request, 7 bits: {lab, exit, code}.
  typedef struct packed {
    logic              lab;
    logic              is_exit;
    logic [CODE_W-1:0] code;
  } lab_req_t;

  function automatic logic [1:0] mode_for(input logic is_exit);
    return is_exit ? MODE_EXIT : MODE_ENTER;
  endfunction

endpackage

// File: rtl/lab_req_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on pop_data while not empty.
module lab_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/lab_access_requester.sv
// Door-side requester: queues reader requests and issues them one at a time to the occupancy controller.
// Build option: define LAB_REQ_PRECHECK_EN to deny enter-when-full / exit-when-empty locally.
module lab_access_requester
  import lab_access_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqLab,
  input  logic        reqExit,
  input  logic [4:0]  reqCode,
  output logic [4:0]  smartCode,
  output logic        lab,
  output logic [1:0]  mode,
  input  logic        unlockDigital,
  input  logic        unlockMera,
  input  logic        restrictionWarnDigital,
  input  logic        restrictionWarnMera,
  input  logic        isFullDigital,
  input  logic        isFullMera,
  input  logic        isEmptyDigital,
  input  logic        isEmptyMera,
  output logic        respValid,
  output logic        respLab,
  output logic [4:0]  respCode,
  output logic [2:0]  respResult,
  output logic        busy
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lab_state_t       state;
  lab_req_t         cur;
  lab_req_t         head;
  lab_req_t         push_entry;
  lab_result_t      result;
  logic [WCW-1:0]   wait_cnt;
  logic [REQ_W-1:0] head_bits;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             sel_unlock;
  logic             sel_warn;

  assign push_entry = '{lab: reqLab, is_exit: reqExit, code: reqCode};
  assign head       = lab_req_t'(head_bits);

  lab_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (reqValid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign reqReady = !fifo_full;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

  // Only the addressed lab's response lines are ever looked at.
  assign sel_unlock = (cur.lab == LAB_MERA) ? unlockMera : unlockDigital;
  assign sel_warn   = (cur.lab == LAB_MERA) ? restrictionWarnMera : restrictionWarnDigital;

`ifdef LAB_REQ_PRECHECK_EN
  logic sel_full;
  logic sel_empty;
  assign sel_full  = (cur.lab == LAB_MERA) ? isFullMera : isFullDigital;
  assign sel_empty = (cur.lab == LAB_MERA) ? isEmptyMera : isEmptyDigital;
`else
  logic unused_flags;
  assign unused_flags = ^{isFullDigital, isFullMera, isEmptyDigital, isEmptyMera};
`endif

  // Request sequencer; mode is loaded on entry to ISSUE so it is valid for that one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cur        <= '0;
      result     <= RES_GRANT;
      wait_cnt   <= '0;
      mode       <= MODE_IDLE;
      smartCode  <= '0;
      lab        <= LAB_DIGITAL;
      respValid  <= 1'b0;
      respLab    <= LAB_DIGITAL;
      respCode   <= '0;
      respResult <= '0;
    end else begin
      respValid <= 1'b0;
      mode      <= MODE_IDLE;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur   <= head;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
`ifdef LAB_REQ_PRECHECK_EN
          if (!cur.is_exit && sel_full) begin
            result <= RES_DENY_FULL;
            state  <= ST_REPORT;
          end else if (cur.is_exit && sel_empty) begin
            result <= RES_DENY_EMPTY;
            state  <= ST_REPORT;
          end else begin
            mode      <= mode_for(cur.is_exit);
            lab       <= cur.lab;
            smartCode <= cur.code;
            state     <= ST_ISSUE;
          end
`else
          mode      <= mode_for(cur.is_exit);
          lab       <= cur.lab;
          smartCode <= cur.code;
          state     <= ST_ISSUE;
`endif
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Warning outranks unlock; a late-but-final-cycle response still beats the timeout.
          if (sel_warn) begin
            result <= RES_DENY_RESTRICT;
            state  <= ST_REPORT;
          end else if (sel_unlock) begin
            result <= RES_GRANT;
            state  <= ST_REPORT;
          end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
            result <= RES_TIMEOUT;
            state  <= ST_REPORT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        ST_REPORT: begin
          respValid  <= 1'b1;
          respLab    <= cur.lab;
          respCode   <= cur.code;
          respResult <= result;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_access_requester.sv
// Bench for lab_access_requester: vector table, directed corner sequences and a randomized
// scoreboard run against a transaction-level model of the door/controller exchange.
module tb_lab_access_requester;

  localparam int TIMEOUT = 4;
  localparam int DEPTH   = 4;
  localparam logic [2:0] R_GRANT    = 3'd0;
  localparam logic [2:0] R_RESTRICT = 3'd1;
  localparam logic [2:0] R_FULL     = 3'd2;
  localparam logic [2:0] R_EMPTY    = 3'd3;
  localparam logic [2:0] R_TIMEOUT  = 3'd4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       reqValid = 1'b0;
  logic       reqReady;
  logic       reqLab = 1'b0;
  logic       reqExit = 1'b0;
  logic [4:0] reqCode = 5'd0;
  logic [4:0] smartCode;
  logic       lab;
  logic [1:0] mode;
  logic       unlockDigital, unlockMera, restrictionWarnDigital, restrictionWarnMera;
  logic       isFullDigital = 1'b0, isFullMera = 1'b0, isEmptyDigital = 1'b0, isEmptyMera = 1'b0;
  logic       respValid;
  logic       respLab;
  logic [4:0] respCode;
  logic [2:0] respResult;
  logic       busy;

  lab_access_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .reqValid(reqValid), .reqReady(reqReady), .reqLab(reqLab), .reqExit(reqExit), .reqCode(reqCode),
    .smartCode(smartCode), .lab(lab), .mode(mode),
    .unlockDigital(unlockDigital), .unlockMera(unlockMera),
    .restrictionWarnDigital(restrictionWarnDigital), .restrictionWarnMera(restrictionWarnMera),
    .isFullDigital(isFullDigital), .isFullMera(isFullMera),
    .isEmptyDigital(isEmptyDigital), .isEmptyMera(isEmptyMera),
    .respValid(respValid), .respLab(respLab), .respCode(respCode), .respResult(respResult),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // kind: 0 silent, 1 unlock, 2 warning, 3 warning+unlock; dly: WAIT cycle index of the pulse.
  typedef struct { logic lab; logic [4:0] code; logic [2:0] res; } exp_t;
  typedef struct { logic lab; logic ex; logic [4:0] code; int kind; int dly; } plan_t;
  typedef struct {
    logic lab; logic ex; logic [4:0] code; int kind; int dly;
    logic fd; logic fm; logic ed; logic em;
    logic [2:0] exp_res; int exp_lat; int exp_issue;
  } vec_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, push_cyc = 0, resp_count = 0, issue_count = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected outcome of one request from the rules alone.
  function automatic logic [2:0] model(input logic l, input logic e, input int kind, input int dly);
`ifdef LAB_REQ_PRECHECK_EN
    if (!e && (l ? isFullMera : isFullDigital)) return R_FULL;
    if (e && (l ? isEmptyMera : isEmptyDigital)) return R_EMPTY;
`endif
    if (kind != 0 && dly < TIMEOUT) return (kind >= 2) ? R_RESTRICT : R_GRANT;
    return R_TIMEOUT;
  endfunction

  function automatic vec_t mk(input logic l, input logic e, input logic [4:0] c, input int k, input int d,
                              input logic fd, input logic fm, input logic ed, input logic em,
                              input logic [2:0] r, input int lat, input int iss);
    vec_t v;
    v.lab = l; v.ex = e; v.code = c; v.kind = k; v.dly = d;
    v.fd = fd; v.fm = fm; v.ed = ed; v.em = em;
    v.exp_res = r; v.exp_lat = lat; v.exp_issue = iss;
    return v;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push_req(input logic l, input logic e, input logic [4:0] c, input int kind, input int dly);
    int n = 0;
    logic [2:0] r;
    reqValid = 1'b1; reqLab = l; reqExit = e; reqCode = c;
    while (!reqReady && n < 200) begin @(negedge CLK); n++; end
    chk("push_accept", 32'(reqReady), 32'd1);
    if (reqReady) begin
      r = model(l, e, kind, dly);
      exp_q.push_back('{l, c, r});
      if (r != R_FULL && r != R_EMPTY) plan_q.push_back('{l, e, c, kind, dly});
      push_cyc = cyc + 1;
    end
    @(negedge CLK);
    reqValid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    while (respValid !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    chk("resp_seen", 32'(respValid), 32'd1);
    lat = cyc - push_cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 600) begin @(negedge CLK); n++; end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Controller stand-in: checks each ISSUE against the plan and pulses the planned response.
  initial begin
    plan_t rp;
    bit armed, prev_issue, hit;
    int widx;
    armed = 0; prev_issue = 0; widx = 0;
    unlockDigital = 0; unlockMera = 0; restrictionWarnDigital = 0; restrictionWarnMera = 0;
    forever begin
      @(negedge CLK);
      unlockDigital = 0; unlockMera = 0; restrictionWarnDigital = 0; restrictionWarnMera = 0;
      if (RST) begin
        armed = 0; prev_issue = 0;
      end else begin
        if (mode !== 2'b10) begin
          issue_count++;
          chk("issue_one_cycle", 32'(prev_issue), 32'd0);
          if (plan_q.size() == 0) begin
            chk("issue_planned", 32'(plan_q.size()), 32'd1);
            armed = 0;
          end else begin
            rp = plan_q.pop_front();
            chk("issue_mode", 32'(mode), rp.ex ? 32'd0 : 32'd1);
            chk("issue_lab", 32'(lab), 32'(rp.lab));
            chk("issue_code", 32'(smartCode), 32'(rp.code));
            armed = 1; widx = 0;
          end
        end else if (armed) begin
          hit = (widx == rp.dly);
          if (rp.lab) begin
            unlockMera = hit && (rp.kind == 1 || rp.kind == 3);
            restrictionWarnMera = hit && (rp.kind >= 2);
            unlockDigital = 1'($urandom_range(0, 1));
            restrictionWarnDigital = 1'($urandom_range(0, 1));
          end else begin
            unlockDigital = hit && (rp.kind == 1 || rp.kind == 3);
            restrictionWarnDigital = hit && (rp.kind >= 2);
            unlockMera = 1'($urandom_range(0, 1));
            restrictionWarnMera = 1'($urandom_range(0, 1));
          end
          widx++;
          if (widx > TIMEOUT + 1) armed = 0;
        end
        prev_issue = (mode !== 2'b10);
      end
    end
  end

  // Response scoreboard: every pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    exp_t got;
    if (!RST && respValid === 1'b1) begin
      resp_count++;
      if (exp_q.size() == 0) chk("resp_unexpected", 32'(respValid), 32'd0);
      else begin
        got = exp_q.pop_front();
        chk("resp_lab", 32'(respLab), 32'(got.lab));
        chk("resp_code", 32'(respCode), 32'(got.code));
        chk("resp_result", 32'(respResult), 32'(got.res));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    int lat, ic, base, n;

    vt[0] = mk(1'b0, 1'b0, 5'd3,  1, 0, 1'b0, 1'b0, 1'b0, 1'b0, R_GRANT,    5, 1);
    vt[1] = mk(1'b1, 1'b0, 5'd7,  3, 0, 1'b0, 1'b0, 1'b0, 1'b0, R_RESTRICT, 5, 1);
    vt[2] = mk(1'b0, 1'b1, 5'h12, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, R_TIMEOUT,  8, 1);
    vt[3] = mk(1'b1, 1'b1, 5'h1f, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, R_GRANT,    8, 1);
    vt[4] = mk(1'b0, 1'b0, 5'h15, 2, 4, 1'b0, 1'b0, 1'b0, 1'b0, R_TIMEOUT,  8, 1);
    vt[5] = mk(1'b1, 1'b0, 5'h01, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, R_RESTRICT, 6, 1);
`ifdef LAB_REQ_PRECHECK_EN
    vt[6] = mk(1'b0, 1'b0, 5'h04, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, R_FULL,     3, 0);
    vt[7] = mk(1'b1, 1'b1, 5'h09, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, R_EMPTY,    3, 0);
`else
    vt[6] = mk(1'b0, 1'b0, 5'h04, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, R_GRANT,    5, 1);
    vt[7] = mk(1'b1, 1'b1, 5'h09, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, R_GRANT,    5, 1);
`endif
    vt[8] = mk(1'b0, 1'b0, 5'h0c, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, R_GRANT,    5, 1);
    vt[9] = mk(1'b1, 1'b1, 5'h10, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, R_GRANT,    7, 1);

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mode", 32'(mode), 32'd2);
    chk("rst_smartCode", 32'(smartCode), 32'd0);
    chk("rst_lab", 32'(lab), 32'd0);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_respLab", 32'(respLab), 32'd0);
    chk("rst_respCode", 32'(respCode), 32'd0);
    chk("rst_respResult", 32'(respResult), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reqReady", 32'(reqReady), 32'd1);

    for (int i = 0; i < 10; i++) begin
      isFullDigital = vt[i].fd; isFullMera = vt[i].fm;
      isEmptyDigital = vt[i].ed; isEmptyMera = vt[i].em;
      ic = issue_count;
      push_req(vt[i].lab, vt[i].ex, vt[i].code, vt[i].kind, vt[i].dly);
      wait_resp(lat);
      chk($sformatf("vec%0d_result", i), 32'(respResult), 32'(vt[i].exp_res));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      @(negedge CLK);
      chk($sformatf("vec%0d_issues", i), 32'(issue_count - ic), 32'(vt[i].exp_issue));
      isFullDigital = 0; isFullMera = 0; isEmptyDigital = 0; isEmptyMera = 0;
      repeat (3) @(negedge CLK);
    end

    // Back-to-back pushes against a silent controller: the FIFO fills behind the in-flight request.
    base = resp_count;
    for (int i = 0; i < 5; i++) push_req(1'(i), 1'b0, 5'(i + 20), 0, 0);
    chk("full_reqReady", 32'(reqReady), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    push_req(1'b1, 1'b1, 5'd25, 0, 0);
    n = 0;
    while (resp_count - base < 6 && n < 400) begin @(negedge CLK); n++; end
    chk("burst_responses", 32'(resp_count - base), 32'd6);
    wait_drain();

    // Reset while waiting with two requests queued: all three are dropped silently.
    for (int i = 0; i < 3; i++) push_req(1'b0, 1'b1, 5'(i + 1), 0, 0);
    ic = issue_count;
    n = 0;
    while (issue_count == ic && n < 50) begin @(negedge CLK); n++; end
    chk("pre_reset_issue", 32'(issue_count - ic), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("reset_mode", 32'(mode), 32'd2);
    chk("reset_respValid", 32'(respValid), 32'd0);
    exp_q.delete();
    plan_q.delete();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_ready", 32'(reqReady), 32'd1);
    base = resp_count;
    repeat (40) @(negedge CLK);
    chk("post_reset_silent", 32'(resp_count - base), 32'd0);

    // Randomized batches; status flags held steady within a batch.
    for (int b = 0; b < 4; b++) begin
      isFullDigital = 1'($urandom_range(0, 1)); isFullMera = 1'($urandom_range(0, 1));
      isEmptyDigital = 1'($urandom_range(0, 1)); isEmptyMera = 1'($urandom_range(0, 1));
      for (int i = 0; i < 10; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        push_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT)));
      end
      wait_drain();
      @(negedge CLK);
    end
    chk("plan_consumed", 32'(plan_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
